// File: rtl/cve2_obi_bus_arbiter.sv
// Shares one OBI manager port between the instruction-fetch and LSU interfaces.
// Address phases are arbitrated and locked until grant; a source-ID FIFO routes in-order responses.
module cve2_obi_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic [2:0]  outstanding_o,
  output logic        busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = 3;
  localparam logic        SrcInstr = 1'b0;
  localparam logic        SrcData  = 1'b1;

  logic [MaxOutstanding-1:0] id_q, id_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      lock_q, lock_d;
  logic                      lock_src_q, lock_src_d;
  logic                      last_q, last_d;

  logic cand_valid, cand_src;
  logic fifo_full, handshake, pop, head_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // Candidate: locked source first, then the lone requester, then the tie-break rule.
  always_comb begin
    cand_valid = instr_req_i | data_req_i;
    cand_src   = SrcInstr;
    if (lock_q) begin
      cand_valid = 1'b1;
      cand_src   = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      cand_src = RoundRobin ? ~last_q : SrcData;
    end else if (data_req_i) begin
      cand_src = SrcData;
    end
  end

  // Full is judged on the registered count, so a same-cycle pop cannot open a slot.
  assign fifo_full = (cnt_q == CntW'(MaxOutstanding));
  assign bus_req_o = cand_valid & ~fifo_full;
  assign handshake = bus_req_o & bus_gnt_i;

  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = 4'hF;
    bus_addr_o  = instr_addr_i;
    bus_wdata_o = '0;
    if (cand_src == SrcData) begin
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = handshake & (cand_src == SrcInstr);
  assign data_gnt_o  = handshake & (cand_src == SrcData);

  // A response with nothing in flight is dropped rather than underflowing the FIFO.
  assign pop            = bus_rvalid_i & (cnt_q != '0);
  assign head_id        = id_q[rptr_q];
  assign instr_rvalid_o = pop & (head_id == SrcInstr);
  assign data_rvalid_o  = pop & (head_id == SrcData);
  assign instr_rdata_o  = pop ? bus_rdata_i : '0;
  assign data_rdata_o   = pop ? bus_rdata_i : '0;
  assign instr_err_o    = instr_rvalid_o & bus_err_i;
  assign data_err_o     = data_rvalid_o & bus_err_i;

  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0) | instr_req_i | data_req_i;

  // Lock, round-robin pointer and source-ID FIFO next state.
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    last_d     = last_q;
    id_d       = id_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;

    if (handshake) begin
      lock_d       = 1'b0;
      id_d[wptr_q] = cand_src;
      wptr_d       = ptr_inc(wptr_q);
      if (RoundRobin) begin
        last_d = cand_src;
      end
    end else if (bus_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = cand_src;
    end

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    unique case ({handshake, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= SrcInstr;
      last_q     <= SrcInstr;
      id_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
      id_q       <= id_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(bus_req_o));
  a_payload_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_req_o |-> !$isunknown({bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}));
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_gnt_o && data_gnt_o));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxOutstanding));
  a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_rvalid_i |-> (cnt_q != '0));
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> ((lock_src_q == SrcData) ? data_req_i : instr_req_i));
`endif

endmodule

// File: doc/cve2_obi_bus_arbiter.md
Name: cve2_obi_bus_arbiter

Overview:
- Shares one OBI manager port between the core's instruction-fetch and data (LSU) interfaces, for single-port memory subsystems.
- Sits between the core top's instr_*/data_* ports and the system bus.
- Arbitrates address phases, locks the selection until grant, and tracks outstanding transactions so in-order responses return to the correct requester.

Parameters:
- MaxOutstanding, 2, depth of the in-flight source-ID FIFO (1..4); total bus transactions accepted but not yet responded.
- RoundRobin, 1'b1, 1 = alternate priority on contention; 0 = fixed priority, data over instr.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- instr_req_i  in  1  fetch request, held until granted
- instr_gnt_o  out  1  fetch address phase accepted
- instr_addr_i  in  32  fetch address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  LSU request, held until granted
- data_gnt_o  out  1  LSU address phase accepted
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_we_o  out  1  bus write enable
- bus_be_o  out  4  bus byte enables
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_rvalid_i  in  1  bus response valid (in order)
- bus_rdata_i  in  32  bus read data
- bus_err_i  in  1  bus error
- outstanding_o  out  3  current in-flight count
- busy_o  out  1  outstanding_o != 0 or any req pending

Behaviour:
- Reset: all outputs 0.
  - FIFO empty.
  - Lock flag cleared.
  - RR pointer favours data on the first tie.
- Candidate selection, combinational:
  - If locked, the locked source.
  - Else the single requester.
  - On a tie: the source not granted last (RoundRobin=1), or data (RoundRobin=0).
- bus_req_o = candidate valid AND FIFO not full.
  - With the FIFO full, no request is issued and both gnt_o stay 0.
- Payload muxing:
  - Payload is driven from the candidate.
  - Instr candidate drives we=0, be=4'hF, wdata=0.
- Grant routing:
  - Winner gnt_o = bus_gnt_i & bus_req_o.
  - The loser's gnt_o is always 0.
  - Never grant both in one cycle.
- Lock: once bus_req_o=1 and bus_gnt_i=0, register lock=1 and the selected source.
  - Selection and payload stay stable until handshake (OBI stability), even if the other requester arrives.
  - Lock clears on the handshake cycle.
- Handshake (req & gnt):
  - Push source ID (0=instr, 1=data) into the FIFO.
  - In RR mode, update the last-granted pointer.
- Response routing:
  - bus_rvalid_i pops the FIFO head.
  - Head ID selects which rvalid_o is asserted, same cycle (zero-latency combinational).
  - rdata/err are broadcast to both; only the selected rvalid is high.
- Push and pop in the same cycle: count unchanged.
  - Full FIFO with a simultaneous pop does NOT allow a new grant that cycle; bus_req_o is based on registered count.
- bus_rvalid_i with empty FIFO: protocol violation.
  - Assertion fires.
  - No rvalid_o is asserted; count stays 0, no underflow.
- FIFO pointers wrap modulo MaxOutstanding.
- Requester dropping req while locked: protocol violation, flagged by assertion.
  - Lock is held until the grant regardless.
- Reset mid-transaction: FIFO and lock flushed immediately.
  - Late bus responses after reset are handled as the empty-FIFO case.
- Assertions required:
  - Known-value checks on bus_req_o, and on payload while bus_req_o is high.
  - Never instr_gnt_o & data_gnt_o.
  - outstanding_o <= MaxOutstanding.

Test Plan:
- Instr-only stream, bus_gnt_i=1, rvalid 1 cycle later: each fetch at 0x100, 0x104 gets instr_rvalid_o with matching rdata; data_rvalid_o stays 0.
- Simultaneous instr_req and data_req (write 0xDEADBEEF to 0x2000, be=4'hC), RoundRobin=1: data granted first, instr next cycle, then alternating while both are held.
- bus_gnt_i held 0 for 3 cycles while instr is requested, data_req rises in cycle 1: bus_addr_o stays at the instr address until grant; data is granted afterwards.
- MaxOutstanding=2, two grants with no rvalid: bus_req_o drops, outstanding_o=2; one rvalid restores bus_req_o the next cycle.
- Responses for interleaved instr,data,instr, with bus_err_i=1 on the second: data_err_o pulses once and instr_err_o stays 0.
- Assert rst_ni with 2 outstanding, then inject a stray bus_rvalid_i: outputs zero, no rvalid_o, outstanding_o=0.
